div_issue_queue: RTL and testbench
==================================

# div_issue_queue

Request queue and sequencer that sits directly upstream and downstream of the single-precision floating-point divider. It buffers tagged (a, b) operand pairs from a valid/ready requester and issues them one at a time over the divider's stb/ack operand handshake. It collects each quotient over the divider's z stb/ack handshake and returns it to the requester with its tag, IEEE class flags and a latency count. Only one divide is in flight at a time, because the divider is single-shot.

## Interface
- DEPTH, 4: request FIFO entries; power of two, ≥2
- TAG_W, 8: request tag width
- aclk  in  1  clock; all logic is on the rising edge
- rstn  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept; equals (count < DEPTH)
- req_tag  in  TAG_W  request tag
- req_a / req_b  in  32  dividend / divisor, IEEE-754 single
- div_a / div_b  out  32  operands to divider; FIFO head, valid while stb high
- div_a_stb / div_b_stb  out  1  operand strobes
- div_a_ack / div_b_ack  in  1  divider operand acks
- div_z  in  32  divider quotient
- div_z_stb  in  1  quotient valid
- div_z_ack  out  1  quotient accepted
- rsp_valid  out  1  response register full
- rsp_ready  in  1  requester accepts response
- rsp_tag  out  TAG_W  tag of the completed request
- rsp_z  out  32  quotient
- rsp_nan / rsp_inf  out  1  flags: rsp_z[30:23]==255 with mantissa ≠0 / ==0
- rsp_cycles  out  8  edges from issue to capture, saturating at 255
- busy  out  1  FIFO non-empty or state ≠ IDLE or rsp_valid

## Operation
- Request FIFO: DEPTH × (TAG_W+64) storage with wrapping read and write pointers and a count.
  - Push when req_valid && req_ready.
  - Pop on an issue transfer.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap mod DEPTH.
- FSM states: IDLE, ISSUE, WAIT_Z.
  - IDLE → ISSUE when count ≠ 0 and rsp_valid == 0.
  - ISSUE: div_a_stb = div_b_stb = 1; div_a/div_b come from the FIFO head.
  - Issue transfer occurs at an edge with div_a_ack && div_b_ack both high. On that edge: pop, latch head tag into inflight_tag, clear the latency counter, go to WAIT_Z.
  - If only one ack is high, there is no transfer; the strobes stay high.
  - WAIT_Z: div_z_ack = !rsp_valid, which is always 1 in practice because issue requires an empty rsp register.
  - At an edge with div_z_stb && div_z_ack: rsp_z ← div_z, rsp_tag ← inflight_tag, flags computed from div_z, rsp_cycles ← counter, rsp_valid ← 1, go to IDLE.
  - The latency counter increments every edge in WAIT_Z and saturates at 255.
- Response register: cleared when rsp_valid && rsp_ready.
  - Capture and drain cannot coincide, since capture requires !rsp_valid.
- div_a_stb, div_b_stb and div_z_ack are pure decodes of state (plus rsp_valid); they are never high outside ISSUE / WAIT_Z.
- The block performs no arithmetic on operands; it passes them through bit-exact.

## Timing
- Reset (rstn low at an edge):
  - state IDLE; FIFO count and pointers 0 (so req_ready = 1).
  - All strobes and acks 0; rsp_valid 0.
  - rsp_tag, rsp_z, rsp_cycles, flags and inflight_tag 0; busy 0.
  - Reset mid-divide discards FIFO contents and any in-flight request. The divider shares rstn and resets with this block.
- Push at edge k: count = 1 after k; state = ISSUE after edge k+1; strobes high from k+1.
- The divider asserts its acks one cycle after it reaches get_value and holds them. Earliest issue transfer is edge k+2.
- Back-to-back: the next issue begins no earlier than the cycle after rsp drains. Minimum drain-to-strobe is 1 cycle.
- rsp_ready held low keeps rsp_valid and the IDLE state; the FIFO continues accepting until full.
- FIFO full: req_ready = 0 in the same cycle count reaches DEPTH. It returns to 1 in the cycle after the pop edge.

## Test plan
- Reset, then push tag 0x11 with a=0x40C00000 (6.0), b=0x40000000 (2.0) -> rsp_valid with rsp_z=0x40400000 (3.0), tag 0x11, nan=inf=0. Issue occurs at edge k+2.
- Push a=0x3F800000, b=0x00000000 -> rsp_z=0x7F800000, rsp_inf=1. Then push a=0, b=0 -> rsp_z=0xFFC00000, rsp_nan=1; tags returned in order.
- DEPTH=4 with rsp_ready=0: push 6 requests (tags 1..6) -> req_ready falls after the 4th push. After rsp_ready=1, all 6 return in tag order 1..6 with correct quotients; count never exceeds 4.
- Stub divider raising div_a_ack alone for 3 cycles, then both -> strobes stay high throughout, exactly one pop occurs, and div_a/div_b stay stable until the transfer edge.
- Stub divider with quotient latency of 60 cycles, and a second stub with 300 -> rsp_cycles = 60 and 255 (saturated), respectively.
- Assert rstn low during WAIT_Z with 2 requests queued -> the next cycle shows all outputs at reset values and req_ready=1. A fresh request afterwards completes normally.

Source files
------------

// File: rtl/div_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : div_issue_queue
//  Purpose  : Request FIFO and single-shot sequencer in front of the
//             single-precision FP divider. Buffers tagged (a, b) pairs
//             from a valid/ready requester and issues one at a time over
//             the divider's operand stb/ack handshake. Collects the quotient
//             over the z stb/ack handshake and returns it with its tag,
//             NaN/Inf class flags and an issue-to-capture latency count.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    aclk, rstn              clock / synchronous active-low reset
//    req_valid/ready/tag/a/b requester side, valid/ready push into FIFO
//    div_a/b, div_a/b_stb    operands and strobes to divider (FIFO head)
//    div_a/b_ack             divider operand acks (transfer when both high)
//    div_z, div_z_stb        quotient from divider
//    div_z_ack               quotient accepted
//    rsp_valid/ready         response register handshake
//    rsp_tag/z/nan/inf       completed request tag, quotient, class flags
//    rsp_cycles              edges from issue to capture, saturating at 255
//    busy                    any work queued, in flight or pending return
// ============================================================================
module div_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic             aclk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    output logic             div_a_stb,
    output logic             div_b_stb,
    input  logic             div_a_ack,
    input  logic             div_b_ack,
    input  logic [31:0]      div_z,
    input  logic             div_z_stb,
    output logic             div_z_ack,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_z,
    output logic             rsp_nan,
    output logic             rsp_inf,
    output logic [7:0]       rsp_cycles,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = TAG_W + 64;
    localparam logic [PTR_W:0]   c_full    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   c_cnt_one = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_ptr_one = (PTR_W)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT_Z = 2'd2
    } state_t;

    state_t              r_state;
    logic [ENT_W-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W:0]      r_count;
    logic [TAG_W-1:0]    r_inflight_tag;
    logic [7:0]          r_lat;
    logic                r_rsp_valid;
    logic [TAG_W-1:0]    r_rsp_tag;
    logic [31:0]         r_rsp_z;
    logic                r_rsp_nan;
    logic                r_rsp_inf;
    logic [7:0]          r_rsp_cycles;

    logic [ENT_W-1:0]    w_head;
    logic                w_req_ready;
    logic                w_push;
    logic                w_issue;
    logic                w_z_ack;
    logic                w_capture;
    logic                w_exp_max;
    logic                w_man_zero;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_req_ready = (r_count < c_full);
    assign w_push      = req_valid && w_req_ready;
    assign w_issue     = (r_state == S_ISSUE) && div_a_ack && div_b_ack;
    // Issue is only ever entered with an empty response register, so this
    // ack is effectively constant-high while waiting for the quotient.
    assign w_z_ack     = (r_state == S_WAIT_Z) && !r_rsp_valid;
    assign w_capture   = w_z_ack && div_z_stb;
    assign w_exp_max   = &div_z[30:23];
    assign w_man_zero  = ~|div_z[22:0];

    // Payload storage needs no reset: validity is tracked by r_count alone.
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_tag, req_a, req_b};
        end
    end

    always_ff @(posedge aclk) begin
        if (!rstn) begin
            r_state        <= S_IDLE;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_inflight_tag <= '0;
            r_lat          <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_tag      <= '0;
            r_rsp_z        <= '0;
            r_rsp_nan      <= 1'b0;
            r_rsp_inf      <= 1'b0;
            r_rsp_cycles   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase

            if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    // Hold off while a response is still waiting to drain.
                    if ((r_count != '0) && !r_rsp_valid) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        r_inflight_tag <= w_head[ENT_W-1:64];
                        r_lat          <= '0;
                        r_state        <= S_WAIT_Z;
                    end
                end
                S_WAIT_Z: begin
                    if (r_lat != 8'hFF) begin
                        r_lat <= r_lat + 8'd1;
                    end
                    if (w_capture) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_tag    <= r_inflight_tag;
                        r_rsp_z      <= div_z;
                        r_rsp_nan    <= w_exp_max && !w_man_zero;
                        r_rsp_inf    <= w_exp_max && w_man_zero;
                        r_rsp_cycles <= r_lat;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = w_req_ready;
    assign div_a      = w_head[63:32];
    assign div_b      = w_head[31:0];
    assign div_a_stb  = (r_state == S_ISSUE);
    assign div_b_stb  = (r_state == S_ISSUE);
    assign div_z_ack  = w_z_ack;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_z      = r_rsp_z;
    assign rsp_nan    = r_rsp_nan;
    assign rsp_inf    = r_rsp_inf;
    assign rsp_cycles = r_rsp_cycles;
    assign busy       = (r_count != '0) || (r_state != S_IDLE) || r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_div_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_issue_queue
//  Purpose  : Directed self-checking bench for div_issue_queue with a
//             configurable stub divider (ack skew, hold, quotient latency).
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_issue_queue;

    logic        aclk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_tag;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_a_stb;
    logic        div_b_stb;
    logic        div_a_ack;
    logic        div_b_ack;
    logic [31:0] div_z;
    logic        div_z_stb;
    logic        div_z_ack;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_tag;
    logic [31:0] rsp_z;
    logic        rsp_nan;
    logic        rsp_inf;
    logic [7:0]  rsp_cycles;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // stub divider configuration
    int stub_lat    = 2;
    int stub_a_only = 0;
    bit stub_hold   = 0;

    div_issue_queue #(.DEPTH(4), .TAG_W(8)) dut (
        .aclk       (aclk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_tag    (req_tag),
        .req_a      (req_a),
        .req_b      (req_b),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_a_stb  (div_a_stb),
        .div_b_stb  (div_b_stb),
        .div_a_ack  (div_a_ack),
        .div_b_ack  (div_b_ack),
        .div_z      (div_z),
        .div_z_stb  (div_z_stb),
        .div_z_ack  (div_z_ack),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_tag    (rsp_tag),
        .rsp_z      (rsp_z),
        .rsp_nan    (rsp_nan),
        .rsp_inf    (rsp_inf),
        .rsp_cycles (rsp_cycles),
        .busy       (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Hand-computed quotients for the operand pairs used below.
    function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40C00000, 32'h40000000}: return 32'h40400000;
            {32'h3F800000, 32'h00000000}: return 32'h7F800000;
            {32'h00000000, 32'h00000000}: return 32'hFFC00000;
            {32'h40000000, 32'h40000000}: return 32'h3F800000;
            {32'h40800000, 32'h40000000}: return 32'h40000000;
            {32'h41000000, 32'h40000000}: return 32'h40800000;
            {32'h41200000, 32'h40000000}: return 32'h40A00000;
            {32'h41400000, 32'h40000000}: return 32'h40C00000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    // Stub divider: acts 1 time unit after each rising edge.
    initial begin
        int          st;
        int          cnt;
        int          ao;
        logic [31:0] oa;
        logic [31:0] ob;
        logic        zack_prev;
        div_a_ack = 1'b0; div_b_ack = 1'b0; div_z_stb = 1'b0; div_z = '0;
        st = 0; cnt = 0; ao = 0; oa = '0; ob = '0; zack_prev = 1'b0;
        forever begin
            @(posedge aclk); #1;
            if (!rstn) begin
                div_a_ack = 1'b0; div_b_ack = 1'b0; div_z_stb = 1'b0; div_z = '0;
                st = 0; zack_prev = 1'b0;
            end else begin
                case (st)
                    0: if (div_a_stb && div_b_stb && !stub_hold) begin
                        oa = div_a; ob = div_b;
                        div_a_ack = 1'b1;
                        ao = stub_a_only;
                        if (ao == 0) div_b_ack = 1'b1;
                        st = 1;
                    end
                    1: if (div_a_ack && div_b_ack) begin
                        div_a_ack = 1'b0; div_b_ack = 1'b0;
                        cnt = stub_lat;
                        st  = 2;
                        if (cnt == 0) begin
                            div_z_stb = 1'b1; div_z = quot(oa, ob); st = 3;
                        end
                    end else begin
                        ao = ao - 1;
                        if (ao == 0) div_b_ack = 1'b1;
                    end
                    2: begin
                        cnt = cnt - 1;
                        if (cnt == 0) begin
                            div_z_stb = 1'b1; div_z = quot(oa, ob); st = 3;
                        end
                    end
                    default: if (zack_prev) begin
                        div_z_stb = 1'b0; st = 0;
                    end
                endcase
                zack_prev = div_z_ack;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    // One clock step; a request offered this cycle and accepted is withdrawn.
    task automatic tick();
        logic acc;
        acc = req_valid && req_ready;
        @(posedge aclk); #2;
        if (acc) req_valid = 1'b0;
    endtask

    task automatic offer(input logic [7:0] t, input logic [31:0] a, input logic [31:0] b);
        req_tag = t; req_a = a; req_b = b; req_valid = 1'b1;
    endtask

    task automatic push(input logic [7:0] t, input logic [31:0] a, input logic [31:0] b);
        offer(t, a, b);
        for (int i = 0; i < 100 && req_valid; i++) tick();
        chk("push_accept", {31'd0, req_valid}, 32'd0);
    endtask

    task automatic wait_rsp(input string name);
        logic found;
        found = rsp_valid;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            found = rsp_valid;
        end
        chk(name, {31'd0, found}, 32'd1);
    endtask

    logic [31:0] fa [6];
    logic [31:0] fz [6];

    initial begin
        fa[0] = 32'h40000000; fz[0] = 32'h3F800000;
        fa[1] = 32'h40800000; fz[1] = 32'h40000000;
        fa[2] = 32'h40C00000; fz[2] = 32'h40400000;
        fa[3] = 32'h41000000; fz[3] = 32'h40800000;
        fa[4] = 32'h41200000; fz[4] = 32'h40A00000;
        fa[5] = 32'h41400000; fz[5] = 32'h40C00000;

        rstn = 1'b0; req_valid = 1'b0; req_tag = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b1;
        tick(); tick(); tick();

        // reset state
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_stb",       {30'd0, div_a_stb, div_b_stb}, 32'd0);
        chk("rst_zack",      {31'd0, div_z_ack}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        tick();

        // basic 6.0 / 2.0, issue at k+2
        push(8'h11, 32'h40C00000, 32'h40000000);            // edge k
        chk("t1_stb_k",   {31'd0, div_a_stb}, 32'd0);
        chk("t1_busy_k",  {31'd0, busy}, 32'd1);
        tick();                                             // edge k+1
        chk("t1_stb_k1",  {30'd0, div_a_stb, div_b_stb}, 32'd3);
        chk("t1_div_a",   div_a, 32'h40C00000);
        chk("t1_div_b",   div_b, 32'h40000000);
        tick();                                             // edge k+2: transfer
        chk("t1_stb_k2",  {31'd0, div_a_stb}, 32'd0);
        chk("t1_zack_k2", {31'd0, div_z_ack}, 32'd1);
        wait_rsp("t1_rsp");
        chk("t1_tag",    {24'd0, rsp_tag}, 32'h11);
        chk("t1_z",      rsp_z, 32'h40400000);
        chk("t1_flags",  {30'd0, rsp_nan, rsp_inf}, 32'd0);
        chk("t1_cycles", {24'd0, rsp_cycles}, 32'd2);
        tick();
        chk("t1_drain",  {31'd0, rsp_valid}, 32'd0);
        chk("t1_idle",   {31'd0, busy}, 32'd0);

        // infinity then NaN, returned in order
        push(8'h21, 32'h3F800000, 32'h00000000);
        push(8'h22, 32'h00000000, 32'h00000000);
        wait_rsp("t2_rsp_a");
        chk("t2_tag_a",   {24'd0, rsp_tag}, 32'h21);
        chk("t2_z_a",     rsp_z, 32'h7F800000);
        chk("t2_flags_a", {30'd0, rsp_nan, rsp_inf}, 32'd1);
        tick();
        wait_rsp("t2_rsp_b");
        chk("t2_tag_b",   {24'd0, rsp_tag}, 32'h22);
        chk("t2_z_b",     rsp_z, 32'hFFC00000);
        chk("t2_flags_b", {30'd0, rsp_nan, rsp_inf}, 32'd2);
        tick();

        // FIFO full with responses stalled
        rsp_ready = 1'b0;
        stub_hold = 1'b1;
        push(8'd1, fa[0], 32'h40000000);
        push(8'd2, fa[1], 32'h40000000);
        push(8'd3, fa[2], 32'h40000000);
        chk("t3_ready_3", {31'd0, req_ready}, 32'd1);
        push(8'd4, fa[3], 32'h40000000);
        chk("t3_ready_4", {31'd0, req_ready}, 32'd0);
        stub_hold = 1'b0;
        push(8'd5, fa[4], 32'h40000000);
        for (int i = 0; i < 8; i++) tick();
        chk("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t3_hold_tag",   {24'd0, rsp_tag}, 32'd1);
        chk("t3_hold_full",  {31'd0, req_ready}, 32'd0);
        chk("t3_hold_stb",   {31'd0, div_a_stb}, 32'd0);
        offer(8'd6, fa[5], 32'h40000000);
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_rsp("t3_rsp");
            chk("t3_tag", {24'd0, rsp_tag}, 32'(i + 1));
            chk("t3_z",   rsp_z, fz[i]);
            tick();
        end
        chk("t3_empty", {31'd0, busy}, 32'd0);

        // a-ack alone for 3 cycles, then both
        stub_a_only = 3;
        push(8'h41, 32'h40C00000, 32'h40000000);            // edge k
        for (int i = 0; i < 4; i++) begin                   // edges k+1..k+4
            tick();
            chk("t4_stb",   {30'd0, div_a_stb, div_b_stb}, 32'd3);
            chk("t4_div_a", div_a, 32'h40C00000);
            chk("t4_div_b", div_b, 32'h40000000);
        end
        tick();                                             // edge k+5: transfer
        chk("t4_stb_off", {31'd0, div_a_stb}, 32'd0);
        stub_a_only = 0;
        wait_rsp("t4_rsp");
        chk("t4_tag", {24'd0, rsp_tag}, 32'h41);
        chk("t4_z",   rsp_z, 32'h40400000);
        tick();
        chk("t4_one_pop", {31'd0, busy}, 32'd0);

        // latency counter and saturation
        stub_lat = 60;
        push(8'h50, 32'h40000000, 32'h40000000);
        wait_rsp("t5_rsp60");
        chk("t5_cycles60", {24'd0, rsp_cycles}, 32'd60);
        tick();
        stub_lat = 300;
        push(8'h51, 32'h40C00000, 32'h40000000);
        wait_rsp("t5_rsp300");
        chk("t5_cycles300", {24'd0, rsp_cycles}, 32'd255);
        tick();

        // reset mid-divide with requests queued
        stub_lat = 50;
        push(8'h71, 32'h40C00000, 32'h40000000);
        push(8'h72, 32'h40C00000, 32'h40000000);
        push(8'h73, 32'h40C00000, 32'h40000000);
        tick(); tick(); tick();
        chk("t6_waitz", {31'd0, div_z_ack}, 32'd1);
        rstn = 1'b0;
        tick();
        chk("t6_req_ready", {31'd0, req_ready}, 32'd1);
        chk("t6_stb_ack",   {29'd0, div_a_stb, div_b_stb, div_z_ack}, 32'd0);
        chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6_rsp_tag",   {24'd0, rsp_tag}, 32'd0);
        chk("t6_rsp_z",     rsp_z, 32'd0);
        chk("t6_cycles",    {24'd0, rsp_cycles}, 32'd0);
        chk("t6_flags",     {30'd0, rsp_nan, rsp_inf}, 32'd0);
        chk("t6_busy",      {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        stub_lat = 2;
        tick();
        push(8'h61, 32'h40C00000, 32'h40000000);
        wait_rsp("t6_rsp");
        chk("t6_tag",    {24'd0, rsp_tag}, 32'h61);
        chk("t6_z",      rsp_z, 32'h40400000);
        chk("t6_cyc2",   {24'd0, rsp_cycles}, 32'd2);
        tick();
        chk("t6_done",   {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
